fifo_stream_reader: RTL
=======================

# fifo_stream_reader

Read-side companion for the 16-deep, 32-bit synchronous FIFO. It drives the FIFO's read enable, absorbs its one-cycle registered read latency and presents the words on a valid/ready stream toward downstream consumers. It sits between the FIFO read port and any backpressuring sink, and sustains one word per cycle when the sink is always ready.

## Interface
- DATA_W, 32, data word width; matches the FIFO data width.
- CNT_W, 5, width of the FIFO occupancy input (FIFO depth 16 plus one bit).
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- rd_en  in  1  permission to issue new FIFO reads; when low, no new reads are issued and in-flight reads still complete.
- fifo_empty  in  1  FIFO empty flag.
- fifo_cnt  in  CNT_W  FIFO occupancy; status only, copied to `level`.
- fifo_dout  in  DATA_W  FIFO read data; valid in the cycle after an accepted read.
- fifo_ren  out  1  FIFO read enable.
- m_data  out  DATA_W  stream data; the head of the skid buffer.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready from the sink.
- level  out  CNT_W+1  fifo_cnt + buf_cnt + inflight; total words committed to the stream and not yet accepted.
- rd_count  out  16  count of accepted stream transfers; wraps modulo 2^16.

## Operation
- State:
  - buf_cnt: 0..2, the number of words held in the 2-entry skid buffer.
  - inflight: 1 bit; set when a FIFO read was issued in the previous cycle.
  - rd_count.
- pop = m_valid & m_ready.
- fifo_ren = rd_en & !fifo_empty & !rst & ((buf_cnt + inflight - pop) < 2).
  - fifo_ren is combinational from m_ready; this path is allowed.
- fifo_ren is never asserted while fifo_empty=1. The FIFO pointer logic is not safe against reads when empty.
- inflight <= fifo_ren on every edge.
- When inflight=1, fifo_dout is written into the buffer tail in that cycle.
- Buffer update per cycle:
  - Push and pop together: buf_cnt is unchanged and the head advances.
  - Push only: buf_cnt + 1.
  - Pop only: buf_cnt - 1.
  - The credit rule guarantees buf_cnt never exceeds 2. Overflow is a design error; simulation asserts on it.
- m_valid = (buf_cnt != 0).
- m_data holds its value while m_valid=1 and m_ready=0. Data must be stable under backpressure.
- rd_count increments by 1 on each pop and wraps from 0xFFFF to 0x0000.
- Word order on the stream equals FIFO read order. No word is dropped or duplicated.

## Timing
- Reset values (asserted asynchronously, held while rst=1):
  - buf_cnt=0, inflight=0, m_valid=0, m_data=0, rd_count=0, fifo_ren=0.
- Latency: a fifo_ren in cycle N puts the word on fifo_dout in cycle N+1. The word is captured at the end of N+1, and m_valid=1 in cycle N+2 at the earliest.
- Throughput: with m_ready held at 1 and the FIFO non-empty, fifo_ren=1 every cycle and there is one transfer per cycle after a 2-cycle fill.
- Backpressure: with m_ready=0 and buffer plus in-flight at 2, fifo_ren stays low. Reads resume in the same cycle m_ready rises, because the credit rule is pop-aware.
- The FIFO goes empty mid-burst: reads stop when fifo_empty=1, and buffered words still drain.
- rd_en falls mid-burst: the in-flight word still lands, and no further reads are issued.
- Reset mid-operation: buffered and in-flight words are discarded. The FIFO is reset by the same system reset.

## Structure
- Shared package fifo_pkg holds:
  - DATA_W, FIFO_DEPTH=16, CNT_W=5, SKID_DEPTH=2.
  - typedef data_t (logic [DATA_W-1:0]).
- Sub-module rd_skid_buf is the 2-entry buffer: push/pop/data ports, buf_cnt output, head/tail pointers that wrap mod 2.
- Top level: credit logic, the inflight flop, the rd_count counter and the level adder.

## Test plan
- Reset, then the FIFO preloaded with 0x00000001..0x00000004 and m_ready=1 -> fifo_ren high for 4 cycles, words out in order starting 2 cycles after the first read, rd_count=4, m_valid=0 afterwards.
- 16 words preloaded, m_ready=0 for 10 cycles, then 1 -> only 2 reads issued while stalled, m_data stable, all 16 words delivered in order, rd_count=16.
- m_ready toggled 1,0,1,0 on a continuous write stream of 0xA0000000+i -> no loss or duplication, and fifo_ren is never high with fifo_empty=1 (asserted every cycle).
- rd_en dropped one cycle after the first read -> exactly 1 word delivered, no further fifo_ren until rd_en returns.
- rst pulsed asynchronously mid-cycle during a burst -> m_valid, fifo_ren and rd_count go to 0 immediately. After release with 2 new words written, those 2 are delivered.
- 65537 transfers -> rd_count wraps to 0x0001.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared widths and types for the FIFO read-side stream reader
//
// Purpose: single source of truth for the data/occupancy widths used by the
// FIFO, the read-side skid buffer and the stream interface.
package fifo_pkg;

  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 16;
  localparam int CNT_W      = 5;   // holds 0..FIFO_DEPTH
  localparam int SKID_DEPTH = 2;   // covers the one-cycle FIFO read latency

  typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/fifo_stream_reader_if.sv
// rtl/fifo_stream_reader_if.sv - valid/ready stream bundle leaving the FIFO reader
//
// Purpose: groups the downstream stream handshake.
// Signals: m_data (word), m_valid (word present), m_ready (sink accepts).
// master = producer (fifo_stream_reader), slave = consumer (sink).
interface fifo_stream_reader_if;
  import fifo_pkg::*;

  data_t m_data;
  logic  m_valid;
  logic  m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);

endinterface

// File: rtl/fifo_stream_reader_skid.sv
// rtl/fifo_stream_reader_skid.sv - two-entry skid buffer (module rd_skid_buf)
//
// Purpose: holds words returned by the FIFO until the sink takes them.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   push_i           write push_data_i into the tail this cycle
//   push_data_i      word to store
//   pop_i            discard the head this cycle
//   head_data_o      oldest stored word (0 after reset)
//   buf_cnt_o        number of stored words, 0..2
module rd_skid_buf
  import fifo_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  data_t      push_data_i,
  input  logic       pop_i,
  output data_t      head_data_o,
  output logic [1:0] buf_cnt_o
);

  data_t      mem_q [SKID_DEPTH];
  logic       head_q, head_d;
  logic       tail_q, tail_d;
  logic [1:0] cnt_q, cnt_d;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (push_i) tail_d = ~tail_q;
    if (pop_i)  head_d = ~head_q;
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // With one word held the tail points at the other slot, so a push never
  // disturbs the head word the sink is looking at.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      head_q   <= 1'b0;
      tail_q   <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_i) mem_q[tail_q] <= push_data_i;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head_data_o = mem_q[head_q];
  assign buf_cnt_o   = cnt_q;

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(push_i && !pop_i && cnt_q == 2'd2))
    else $error("rd_skid_buf overflow");

endmodule

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - FIFO read-port to valid/ready stream adapter
//
// Purpose: issues FIFO reads while the skid buffer has room for the result,
// absorbs the one-cycle read latency and presents words on a stream.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   rd_en        permission to start new FIFO reads
//   fifo_empty   FIFO empty flag
//   fifo_cnt     FIFO occupancy (status only)
//   fifo_dout    FIFO read data, valid the cycle after fifo_ren
//   fifo_ren     FIFO read enable
//   strm         stream master: m_data / m_valid / m_ready
//   level        words written to the FIFO and not yet accepted downstream
//   rd_count     accepted stream transfers, modulo 2^16
module fifo_stream_reader
  import fifo_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rd_en,
  input  logic                 fifo_empty,
  input  logic [CNT_W-1:0]     fifo_cnt,
  input  data_t                fifo_dout,
  output logic                 fifo_ren,
  fifo_stream_reader_if.master strm,
  output logic [CNT_W:0]       level,
  output logic [15:0]          rd_count
);

  logic [1:0]  buf_cnt;
  logic        inflight_q, inflight_d;
  logic [15:0] rd_count_q, rd_count_d;
  logic        pop;
  logic [2:0]  committed;

  assign pop = strm.m_valid & strm.m_ready;

  // Slots that will still be occupied after this cycle's pop; a read issued
  // now lands next cycle, so it needs one of those slots to be free. Counting
  // the pop lets reads restart in the same cycle the sink becomes ready.
  assign committed = {1'b0, buf_cnt} + {2'b00, inflight_q} - {2'b00, pop};
  assign fifo_ren  = rd_en & ~fifo_empty & ~rst & (committed < 3'(SKID_DEPTH));

  assign inflight_d = fifo_ren;
  assign rd_count_d = rd_count_q + {15'd0, pop};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q <= 1'b0;
      rd_count_q <= 16'd0;
    end else begin
      inflight_q <= inflight_d;
      rd_count_q <= rd_count_d;
    end
  end

  rd_skid_buf u_skid (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_data_i (fifo_dout),
    .pop_i       (pop),
    .head_data_o (strm.m_data),
    .buf_cnt_o   (buf_cnt)
  );

  assign strm.m_valid = (buf_cnt != 2'd0);
  assign rd_count     = rd_count_q;
  assign level        = {1'b0, fifo_cnt}
                      + {{(CNT_W-1){1'b0}}, buf_cnt}
                      + {{CNT_W{1'b0}}, inflight_q};

endmodule
